// File: rtl/switch_cfg_loader.sv
// ---------------------------------------------------------------------------
// switch_cfg_loader
//
// Purpose:
//   Byte-stream configuration loader for one switch-matrix tile. A framed
//   byte stream arrives over a valid/ready handshake. The frame is buffered
//   into a shadow register file and validated. On success it is committed
//   atomically to the active config bus that drives the matrix.
//
//   Frame layout:
//     0xA5 header
//     NWORDS data bytes (word k = byte[5:0])
//     one checksum byte (XOR of the header and all data bytes)
//
//   Selector word layout:
//     [5:3] source index
//     [2:0] side select (0 = off, 1 = top, 2 = right, 3 = bottom, 4 = left)
//
// Handshake:
//   A byte transfers on a rising clk edge where in_valid && in_ready are
//   both high. The producer holds in_data stable while in_valid is high and
//   in_ready is low. in_valid low simply stalls the loader, with no timeout.
//
// Ports:
//   clk       in   single clock
//   rst       in   synchronous, active-high reset
//   in_valid  in   in_data carries a byte
//   in_data   in   8-bit configuration stream byte
//   in_ready  out  loader accepts in_data this cycle (low during COMMIT
//                  and while in reset)
//   cfg_out   out  active config, NWORDS*CFG_W bits; word k at
//                  [CFG_W*k +: CFG_W]. Word order is top[0..NTB-1],
//                  bottom[0..NTB-1], left[0..NLR-1], right[0..NLR-1].
//   busy      out  frame in progress (state != IDLE)
//   done      out  one-cycle pulse: frame committed
//   err       out  one-cycle pulse: frame rejected
//
// Optional build macro CFG_READBACK_EN adds these ports:
//   rb_addr   in   5-bit word address
//   rb_data   out  registered readback of the active cfg_out word
//                  (0 when rb_addr >= NWORDS)
// ---------------------------------------------------------------------------
module switch_cfg_loader #(
  parameter int NTB   = 5,
  parameter int NLR   = 4,
  parameter int CFG_W = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [7:0]                           in_data,
  output logic                                 in_ready,
  output logic [(2*NTB+2*NLR)*CFG_W-1:0]       cfg_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
`ifdef CFG_READBACK_EN
  ,
  input  logic [4:0]                           rb_addr,
  output logic [CFG_W-1:0]                     rb_data
`endif
);

  localparam int NWORDS = 2*NTB + 2*NLR;
  localparam int CFG_BITS = NWORDS * CFG_W;
  localparam logic [4:0] LAST_CNT = 5'(NWORDS - 1);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CSUM   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [7:0]            xsum_q, xsum_d;
  logic                  bad_q, bad_d;
  logic [CFG_W-1:0]      shadow_q [NWORDS];
  logic [CFG_W-1:0]      shadow_d [NWORDS];
  logic [CFG_BITS-1:0]   cfg_q, cfg_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;

  // A data byte is illegal if:
  //   - either top bit is set,
  //   - the side code is unknown, or
  //   - the source index is beyond the wire count of the selected side.
  function automatic logic word_bad(input logic [7:0] b);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       bad;
    sel = b[2:0];
    idx = b[5:3];
    bad = 1'b0;
    if (b[7:6] != 2'b00) begin
      bad = 1'b1;
    end
    if (sel > 3'd4) begin
      bad = 1'b1;
    end
    if (((sel == 3'd1) || (sel == 3'd3)) && (int'(idx) >= NTB)) begin
      bad = 1'b1;
    end
    if (((sel == 3'd2) || (sel == 3'd4)) && (int'(idx) >= NLR)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xsum_d   = xsum_q;
    bad_d    = bad_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Anything other than the header is consumed and dropped silently.
        if (accept && (in_data == HEADER)) begin
          state_d = LOAD;
          cnt_d   = 5'd0;
          xsum_d  = HEADER;
          bad_d   = 1'b0;
        end
      end

      LOAD: begin
        // 0xA5 here is ordinary data; there is no resync inside a frame.
        if (accept) begin
          shadow_d[cnt_q] = in_data[CFG_W-1:0];
          xsum_d          = xsum_q ^ in_data;
          cnt_d           = cnt_q + 5'd1;
          if (word_bad(in_data)) begin
            bad_d = 1'b1;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = CSUM;
          end
        end
      end

      CSUM: begin
        if (accept) begin
          if (in_data != xsum_q) begin
            bad_d = 1'b1;
          end
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        // The whole shadow lands at once. A rejected frame leaves the
        // active config untouched.
        if (!bad_q) begin
          for (int k = 0; k < NWORDS; k++) begin
            cfg_d[k*CFG_W +: CFG_W] = shadow_q[k];
          end
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state. in_ready and busy
    // therefore track the state the FSM is entering.
    in_ready_d = (state_d != COMMIT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      xsum_q     <= 8'd0;
      bad_q      <= 1'b0;
      cfg_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < NWORDS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xsum_q     <= xsum_d;
      bad_q      <= bad_d;
      cfg_q      <= cfg_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      for (int k = 0; k < NWORDS; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign in_ready = in_ready_q;
  assign cfg_out  = cfg_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef CFG_READBACK_EN
  logic [CFG_W-1:0] rb_data_q, rb_data_d;

  // Reads the active word, not the shadow.
  // Out-of-range addresses return 0.
  always_comb begin
    rb_data_d = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (rb_addr == 5'(k)) begin
        rb_data_d = cfg_q[k*CFG_W +: CFG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data_q <= '0;
    end else begin
      rb_data_q <= rb_data_d;
    end
  end

  assign rb_data = rb_data_q;
`endif

endmodule

// File: tb/tb_switch_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_switch_cfg_loader
//
// Directed test of switch_cfg_loader. Frames are driven byte by byte.
// Checks are made on the active config bus, the done/err pulses,
// in_ready and busy.
// ---------------------------------------------------------------------------
module tb_switch_cfg_loader;

  localparam int NW = 18;
  localparam int CB = NW * 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [CB-1:0] cfg_out;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;
  int done_total = 0;
  int err_total = 0;
  int both_total = 0;

  logic [7:0]    fr [NW];
  logic [7:0]    cs;
  logic [CB-1:0] exp_cfg;
  logic [CB-1:0] pat09;

  switch_cfg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Clock and pulse monitors. Pulses are counted on the falling edge,
  // away from the active edge.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_total++;
    if (err) err_total++;
    if (done && err) both_total++;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Present one byte and hold it until a handshake edge has passed.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Header, data bytes and checksum. Optionally pauses in_valid after
  // stall_after data bytes.
  task automatic send_frame(input logic [7:0] d [NW], input logic [7:0] c,
                            input int stall_after, input string tag);
    send_byte(8'hA5);
    chk({tag, "_busy_load"}, {127'd0, busy}, 128'd1);
    for (int i = 0; i < NW; i++) begin
      if (i == stall_after) begin
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_busy_stall"}, {126'd0, busy, done}, {126'd0, 2'b10});
      end
      send_byte(d[i]);
    end
    send_byte(c);
  endtask

  // Called one cycle after the checksum handshake (COMMIT cycle).
  task automatic finish_frame(input logic exp_done, input logic [CB-1:0] ec,
                              input string tag);
    chk({tag, "_ready_commit"}, {127'd0, in_ready}, 128'd0);
    chk({tag, "_nopulse_early"}, {126'd0, done, err}, 128'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done"}, {127'd0, done}, {127'd0, exp_done});
    chk({tag, "_err"}, {127'd0, err}, {127'd0, !exp_done});
    chk({tag, "_cfg"}, {20'd0, cfg_out}, {20'd0, ec});
    @(posedge clk);
    #1;
    chk({tag, "_idle_after"}, {125'd0, done, err, busy}, 128'd0);
    chk({tag, "_ready_after"}, {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    for (int k = 0; k < NW; k++) pat09[k*6 +: 6] = 6'b001_001;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_cfg", {20'd0, cfg_out}, 128'd0);
    chk("rst_flags", {125'd0, busy, done, err}, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", {127'd0, in_ready}, 128'd1);
    chk("idle_flags", {125'd0, busy, done, err}, 128'd0);

    // All-zero frame: checksum is just the header.
    for (int k = 0; k < NW; k++) fr[k] = 8'h00;
    send_frame(fr, 8'hA5, -1, "zero");
    finish_frame(1'b1, '0, "zero");

    // Eighteen 0x09 bytes XOR to 0, so the checksum is 0xA5.
    // Includes a mid-frame stall.
    for (int k = 0; k < NW; k++) fr[k] = 8'h09;
    send_frame(fr, 8'hA5, 7, "p09");
    finish_frame(1'b1, pat09, "p09");

    // Side select 5 is illegal. Checksum A5^05 = A0 is correct.
    for (int k = 0; k < NW; k++) fr[k] = 8'h00;
    fr[0] = 8'h05;
    send_frame(fr, 8'hA0, -1, "sel5");
    finish_frame(1'b0, pat09, "sel5");

    // Legal data with a wrong checksum.
    for (int k = 0; k < NW; k++) fr[k] = 8'h09;
    send_frame(fr, 8'h00, -1, "badcs");
    finish_frame(1'b0, pat09, "badcs");

    // Right side, index 4 >= NLR. Checksum A5^22 = 87.
    for (int k = 0; k < NW; k++) fr[k] = 8'h00;
    fr[0] = 8'h22;
    send_frame(fr, 8'h87, -1, "idx4");
    finish_frame(1'b0, pat09, "idx4");

    // 0xA5 inside LOAD is data; its top bits make the word illegal.
    for (int k = 0; k < NW; k++) fr[k] = 8'h00;
    fr[3] = 8'hA5;
    send_frame(fr, 8'h00, -1, "a5data");
    finish_frame(1'b0, pat09, "a5data");

    // Leading junk, then a frame with a distinct legal word in each slot.
    send_byte(8'h11);
    send_byte(8'h22);
    chk("junk_flags", {125'd0, busy, done, err}, 128'd0);
    for (int k = 0; k < 5; k++) fr[k]     = 8'((k << 3) | 1);
    for (int k = 0; k < 5; k++) fr[5 + k] = 8'((k << 3) | 3);
    for (int k = 0; k < 4; k++) fr[10 + k] = 8'((k << 3) | 4);
    for (int k = 0; k < 4; k++) fr[14 + k] = 8'((k << 3) | 2);
    cs = 8'hA5;
    for (int k = 0; k < NW; k++) begin
      cs = cs ^ fr[k];
      exp_cfg[k*6 +: 6] = fr[k][5:0];
    end
    send_frame(fr, cs, -1, "mix");
    finish_frame(1'b1, exp_cfg, "mix");

    // Reset after 10 data bytes: frame discarded, cfg cleared, no pulse.
    send_byte(8'hA5);
    for (int k = 0; k < 10; k++) send_byte(8'h09);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cfg", {20'd0, cfg_out}, 128'd0);
    chk("midrst_flags", {125'd0, busy, done, err}, 128'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_flags", {125'd0, busy, done, err}, 128'd0);

    // A full frame after the reset proves the counter restarted.
    for (int k = 0; k < NW; k++) fr[k] = 8'h09;
    send_frame(fr, 8'hA5, -1, "after");
    finish_frame(1'b1, pat09, "after");

    repeat (2) @(posedge clk);
    #1;
    chk("done_total", 128'(done_total), 128'd4);
    chk("err_total", 128'(err_total), 128'd4);
    chk("done_err_overlap", 128'(both_total), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
